// File: rtl/decryption_scheduler.sv
// Shares one byte stream among three decryption engines through a small FIFO and message-level FSM.
// Optional message/drop statistics counters are enabled by DECRYPT_SCHED_STATS_EN.
module decryption_scheduler #(
  parameter int unsigned        D_WIDTH    = 8,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [D_WIDTH-1:0] END_CHAR   = 8'hFA
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [1:0]             sel_i,
  output logic                   busy_o,
  output logic [D_WIDTH-1:0]     eng_data_o,
  output logic [2:0]             eng_valid_o,
  input  logic [2:0]             eng_busy_i,
  input  logic [3*D_WIDTH-1:0]   eng_data_i,
  input  logic [2:0]             eng_valid_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
  output logic                   error_o
`ifdef DECRYPT_SCHED_STATS_EN
  ,
  output logic [15:0]            msg_cnt_o,
  output logic [15:0]            drop_cnt_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = D_WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DROP   = 2'd3;

  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_state;
  logic [1:0]         r_sel_q;
  logic               r_seen_busy;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [1:0]         w_head_sel;
  logic [D_WIDTH-1:0] w_head_data;
  logic [1:0]         w_state_nxt;
  logic               w_sel_ld;
  logic               w_fwd;
  logic               w_err;
  logic               w_eng_busy;
  logic               w_eng_valid;
  logic               w_active;
  logic [D_WIDTH-1:0] w_eng_rdata;
  logic [3:0]         w_busy_vec;
  logic [3:0]         w_valid_vec;

  assign busy_o      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = valid_i & ~busy_o;
  assign w_head_sel  = r_mem[r_rd_ptr][ENT_W-1 -: 2];
  assign w_head_data = r_mem[r_rd_ptr][D_WIDTH-1:0];

  // Pad to four entries so a latched select of 3 never indexes out of range
  assign w_busy_vec  = {1'b0, eng_busy_i};
  assign w_valid_vec = {1'b0, eng_valid_i};
  assign w_eng_busy  = w_busy_vec[r_sel_q];
  assign w_eng_valid = w_valid_vec[r_sel_q];
  assign w_active    = (r_state == S_STREAM) || (r_state == S_DRAIN);

  always_comb begin
    w_eng_rdata = '0;
    case (r_sel_q)
      2'd0:    w_eng_rdata = eng_data_i[0 +: D_WIDTH];
      2'd1:    w_eng_rdata = eng_data_i[D_WIDTH +: D_WIDTH];
      2'd2:    w_eng_rdata = eng_data_i[2*D_WIDTH +: D_WIDTH];
      default: w_eng_rdata = '0;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {sel_i, data_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Message-level next-state and FIFO pop decision
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_sel_ld    = 1'b0;
    w_fwd       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_sel_ld    = 1'b1;
          w_state_nxt = (w_head_sel == 2'd3) ? S_DROP : S_STREAM;
        end
      end
      S_STREAM: begin
        if (!w_empty && !w_eng_busy) begin
          w_pop = 1'b1;
          w_fwd = 1'b1;
          if (w_head_data == END_CHAR) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_seen_busy && !w_eng_busy && !w_eng_valid) w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_data == END_CHAR) begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel_q     <= 2'd0;
      r_seen_busy <= 1'b0;
      eng_data_o  <= '0;
      eng_valid_o <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_ld) r_sel_q <= w_head_sel;
      if (r_state == S_DRAIN) r_seen_busy <= r_seen_busy | w_eng_busy;
      else                    r_seen_busy <= 1'b0;
      if (w_fwd) begin
        eng_data_o  <= w_head_data;
        eng_valid_o <= 3'(3'b001 << r_sel_q);
      end else begin
        eng_valid_o <= '0;
      end
      valid_o <= w_active & w_eng_valid;
      if (w_active && w_eng_valid) data_o <= w_eng_rdata;
      error_o <= w_err;
    end
  end

`ifdef DECRYPT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (r_state == S_DRAIN && w_state_nxt == S_IDLE) msg_cnt_o  <= msg_cnt_o + 16'd1;
      if (r_state == S_DROP  && w_state_nxt == S_IDLE) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule
